// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register file slave.
interface axi4_lite_regfile_if #(
  parameter int ADDRESS_SIZE = 6,
  parameter int DATA_SIZE    = 32
);
  logic [ADDRESS_SIZE-1:0]  s_axi_araddr;
  logic                     s_axi_arvalid;
  logic                     s_axi_arready;
  logic [DATA_SIZE-1:0]     s_axi_rdata;
  logic [1:0]               s_axi_rresp;
  logic                     s_axi_rvalid;
  logic                     s_axi_rready;
  logic [ADDRESS_SIZE-1:0]  s_axi_awaddr;
  logic                     s_axi_awvalid;
  logic                     s_axi_awready;
  logic [DATA_SIZE-1:0]     s_axi_wdata;
  logic [DATA_SIZE/8-1:0]   s_axi_wstrb;
  logic                     s_axi_wvalid;
  logic                     s_axi_wready;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite control register file with optional skid-buffered channels,
// byte strobes, SLVERR on out-of-range indices and per-register write pulses.

module axi4_lite_regfile_skid #(
  parameter int WIDTH = 1,
  parameter bit SLICE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_clk_i,
  input  logic             i_inValid,
  output logic             o_inReady,
  input  logic [WIDTH-1:0] i_inData,
  output logic             o_outValid,
  input  logic             i_outReady,
  output logic [WIDTH-1:0] o_outData
);
  if (SLICE) begin : g_slice
    logic             r_outValid;
    logic             r_skidValid;
    logic             r_inReady;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] r_skidData;
    logic             w_outFree;
    logic             w_inHs;
    logic             w_nextSkidValid;

    assign w_outFree = !r_outValid || i_outReady;
    assign w_inHs    = i_inValid && r_inReady;

    always_comb begin
      w_nextSkidValid = r_skidValid;
      if (w_outFree) w_nextSkidValid = 1'b0;
      else if (w_inHs) w_nextSkidValid = 1'b1;
    end

    // Input ready is registered; the skid entry absorbs the beat accepted while the output stalls.
    always_ff @(posedge clk_i) begin
      if (rst_clk_i) begin
        r_outValid  <= 1'b0;
        r_skidValid <= 1'b0;
        r_inReady   <= 1'b0;
        r_outData   <= '0;
        r_skidData  <= '0;
      end else begin
        r_skidValid <= w_nextSkidValid;
        r_inReady   <= !w_nextSkidValid;
        if (w_outFree) begin
          if (r_skidValid) begin
            r_outValid <= 1'b1;
            r_outData  <= r_skidData;
          end else begin
            r_outValid <= w_inHs;
            if (w_inHs) r_outData <= i_inData;
          end
        end else if (w_inHs) begin
          r_skidData <= i_inData;
        end
      end
    end

    assign o_inReady  = r_inReady;
    assign o_outValid = r_outValid;
    assign o_outData  = r_outData;
  end else begin : g_direct
    assign o_inReady  = i_outReady;
    assign o_outValid = i_inValid;
    assign o_outData  = i_inData;
  end
endmodule

module axi4_lite_regfile #(
  parameter int ADDRESS_SIZE = 6,
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 8,
  parameter bit REG_SLICE    = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_clk_i,
  axi4_lite_regfile_if.slave            s_axi,
  output logic [NUM_REGS*DATA_SIZE-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse_o
);
  localparam int STRB_W   = DATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDRESS_SIZE - ADDR_LSB;

  typedef enum logic { W_IDLE, W_RESP } wState_t;
  typedef enum logic { R_IDLE, R_DATA } rState_t;

  wState_t              r_wState, w_wStateNext;
  rState_t              r_rState, w_rStateNext;
  logic [DATA_SIZE-1:0] r_regs [NUM_REGS];
  logic                 r_live;
  logic                 r_awHeld, r_wHeld;
  logic [IDX_W-1:0]     r_awIdx;
  logic [DATA_SIZE-1:0] r_wData;
  logic [STRB_W-1:0]    r_wStrb;
  logic [1:0]           r_bResp;
  logic [NUM_REGS-1:0]  r_pulse;
  logic [DATA_SIZE-1:0] r_rData;
  logic [1:0]           r_rResp;

  logic                 w_arValid, w_arReady, w_arHs;
  logic [IDX_W-1:0]     w_arIdx;
  logic                 w_rValid, w_rReady;
  logic [DATA_SIZE+1:0] w_rOut;
  logic                 w_awValid, w_awReady, w_awHs;
  logic [IDX_W-1:0]     w_awIdx;
  logic                        w_wValid, w_wReady, w_wHs;
  logic [DATA_SIZE+STRB_W-1:0] w_wBeat;
  logic                 w_bValid, w_bReady;
  logic [1:0]           w_bOut;
  logic                 w_commit, w_bDone;
  logic [IDX_W-1:0]     w_cmtIdx;
  logic [DATA_SIZE-1:0] w_cmtData;
  logic [STRB_W-1:0]    w_cmtStrb;
  logic [NUM_REGS-1:0]  w_wSel, w_rSel;
  logic [DATA_SIZE-1:0] w_rdMux;
  logic                 w_unusedAddrLsb;

  // Byte-lane address bits never select anything.
  assign w_unusedAddrLsb = &{1'b0, s_axi.s_axi_araddr[ADDR_LSB-1:0], s_axi.s_axi_awaddr[ADDR_LSB-1:0]};

  axi4_lite_regfile_skid #(.WIDTH(IDX_W), .SLICE(REG_SLICE)) u_arSkid (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .i_inValid(s_axi.s_axi_arvalid), .o_inReady(s_axi.s_axi_arready),
    .i_inData(s_axi.s_axi_araddr[ADDRESS_SIZE-1:ADDR_LSB]),
    .o_outValid(w_arValid), .i_outReady(w_arReady), .o_outData(w_arIdx)
  );

  axi4_lite_regfile_skid #(.WIDTH(DATA_SIZE + 2), .SLICE(REG_SLICE)) u_rSkid (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .i_inValid(w_rValid), .o_inReady(w_rReady), .i_inData({r_rData, r_rResp}),
    .o_outValid(s_axi.s_axi_rvalid), .i_outReady(s_axi.s_axi_rready), .o_outData(w_rOut)
  );

  axi4_lite_regfile_skid #(.WIDTH(IDX_W), .SLICE(REG_SLICE)) u_awSkid (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .i_inValid(s_axi.s_axi_awvalid), .o_inReady(s_axi.s_axi_awready),
    .i_inData(s_axi.s_axi_awaddr[ADDRESS_SIZE-1:ADDR_LSB]),
    .o_outValid(w_awValid), .i_outReady(w_awReady), .o_outData(w_awIdx)
  );

  axi4_lite_regfile_skid #(.WIDTH(DATA_SIZE + STRB_W), .SLICE(REG_SLICE)) u_wSkid (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .i_inValid(s_axi.s_axi_wvalid), .o_inReady(s_axi.s_axi_wready),
    .i_inData({s_axi.s_axi_wdata, s_axi.s_axi_wstrb}),
    .o_outValid(w_wValid), .i_outReady(w_wReady), .o_outData(w_wBeat)
  );

  axi4_lite_regfile_skid #(.WIDTH(2), .SLICE(REG_SLICE)) u_bSkid (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .i_inValid(w_bValid), .o_inReady(w_bReady), .i_inData(r_bResp),
    .o_outValid(s_axi.s_axi_bvalid), .i_outReady(s_axi.s_axi_bready), .o_outData(w_bOut)
  );

  assign s_axi.s_axi_rdata = w_rOut[DATA_SIZE+1:2];
  assign s_axi.s_axi_rresp = w_rOut[1:0];
  assign s_axi.s_axi_bresp = w_bOut;

  // r_live keeps every core ready low through reset and raises it on the first cycle after.
  assign w_awReady = (r_wState == W_IDLE) && r_live && !r_awHeld;
  assign w_wReady  = (r_wState == W_IDLE) && r_live && !r_wHeld;
  assign w_bValid  = (r_wState == W_RESP);
  assign w_awHs    = w_awValid && w_awReady;
  assign w_wHs     = w_wValid && w_wReady;
  assign w_arReady = (r_rState == R_IDLE) && r_live;
  assign w_arHs    = w_arValid && w_arReady;
  assign w_rValid  = (r_rState == R_DATA);

  assign w_cmtIdx  = w_awHs ? w_awIdx : r_awIdx;
  assign w_cmtData = w_wHs ? w_wBeat[DATA_SIZE+STRB_W-1:STRB_W] : r_wData;
  assign w_cmtStrb = w_wHs ? w_wBeat[STRB_W-1:0] : r_wStrb;

  always_comb begin
    w_wSel  = '0;
    w_rSel  = '0;
    w_rdMux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_wSel[k] = (w_cmtIdx == IDX_W'(k));
      w_rSel[k] = (w_arIdx == IDX_W'(k));
      if (w_rSel[k]) w_rdMux = r_regs[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      r_wState <= W_IDLE;
      r_rState <= R_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_wState <= w_wStateNext;
      r_rState <= w_rStateNext;
      r_live   <= 1'b1;
    end
  end

  // Commit fires on the edge where address and data are both present, whichever arrived last.
  always_comb begin
    w_wStateNext = r_wState;
    w_commit     = 1'b0;
    w_bDone      = 1'b0;
    case (r_wState)
      W_IDLE: begin
        if ((r_awHeld || w_awHs) && (r_wHeld || w_wHs)) begin
          w_commit     = 1'b1;
          w_wStateNext = W_RESP;
        end
      end
      W_RESP: begin
        if (w_bReady) begin
          w_bDone      = 1'b1;
          w_wStateNext = W_IDLE;
        end
      end
      default: w_wStateNext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (w_arHs) w_rStateNext = R_DATA;
      R_DATA:  if (w_rReady) w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_awIdx  <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
      r_bResp  <= 2'b00;
      r_pulse  <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_pulse <= '0;
      if (w_awHs) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= w_awIdx;
      end
      if (w_wHs) begin
        r_wHeld <= 1'b1;
        r_wData <= w_cmtData;
        r_wStrb <= w_cmtStrb;
      end
      if (w_commit) begin
        r_bResp <= (|w_wSel) ? 2'b00 : 2'b10;
        r_pulse <= w_wSel;
        for (int k = 0; k < NUM_REGS; k++)
          for (int b = 0; b < STRB_W; b++)
            if (w_wSel[k] && w_cmtStrb[b]) r_regs[k][b*8 +: 8] <= w_cmtData[b*8 +: 8];
      end
      if (w_bDone) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end
    end
  end

  // Capture uses pre-edge register contents, so a same-edge commit is not visible to this read.
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      r_rData <= '0;
      r_rResp <= 2'b00;
    end else if (w_arHs) begin
      r_rData <= w_rdMux;
      r_rResp <= (|w_rSel) ? 2'b00 : 2'b10;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regsOut
    assign regs_o[k*DATA_SIZE +: DATA_SIZE] = r_regs[k];
  end
  assign wr_pulse_o = r_pulse;
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed and scoreboarded checks for the AXI4-Lite register file (skid buffers enabled).
module tb_axi4_lite_regfile;
  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int NR      = 8;
  localparam int TIMEOUT = 60;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*DW-1:0]  regs;
  logic [NR-1:0]     pulse;
  int                checks = 0;
  int                fails = 0;
  int                pulseCount [NR] = '{default: 0};
  int                pulseTotal = 0;
  int                expPulse [NR];
  logic [DW-1:0]     model [NR];

  axi4_lite_regfile_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  axi4_lite_regfile #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .NUM_REGS(NR), .REG_SLICE(1'b1)) dut (
    .clk_i(clk), .rst_clk_i(rst), .s_axi(bus.slave), .regs_o(regs), .wr_pulse_o(pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) begin
      if (pulse[k]) begin
        pulseCount[k] = pulseCount[k] + 1;
        pulseTotal    = pulseTotal + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[5:2]);
    if (idx < NR) begin
      expPulse[idx]++;
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  function automatic logic [NR*DW-1:0] modelFlat();
    logic [NR*DW-1:0] flat;
    for (int k = 0; k < NR; k++) flat[k*DW +: DW] = model[k];
    return flat;
  endfunction

  function automatic void modelClear();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endfunction

  task automatic idleBus();
    bus.s_axi_araddr  = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    bus.s_axi_awaddr  = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0; bus.s_axi_wstrb   = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready  = 1'b0;
  endtask

  task automatic sendAw(input logic [AW-1:0] addr, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_axi_awready && n < TIMEOUT);
    checkOutput("awReady", bus.s_axi_awready, 1'b1);
    @(posedge clk); #1; bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [DW-1:0] data, input logic [3:0] strb, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_axi_wready && n < TIMEOUT);
    checkOutput("wReady", bus.s_axi_wready, 1'b1);
    @(posedge clk); #1; bus.s_axi_wvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [AW-1:0] addr, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_axi_arready && n < TIMEOUT);
    checkOutput("arReady", bus.s_axi_arready, 1'b1);
    @(posedge clk); #1; bus.s_axi_arvalid = 1'b0;
  endtask

  // Response is held unready for dly cycles, checking it stays frozen meanwhile.
  task automatic waitB(input int dly, output logic [1:0] resp);
    int n = 0;
    logic stable = 1'b1;
    logic [1:0] first;
    do begin @(negedge clk); n++; end while (!bus.s_axi_bvalid && n < TIMEOUT);
    checkOutput("bValid", bus.s_axi_bvalid, 1'b1);
    first = bus.s_axi_bresp;
    repeat (dly) begin
      @(negedge clk);
      if (!bus.s_axi_bvalid || bus.s_axi_bresp !== first) stable = 1'b0;
    end
    if (dly > 0) checkOutput("bHold", stable, 1'b1);
    resp = bus.s_axi_bresp;
    bus.s_axi_bready = 1'b1;
    @(posedge clk); #1; bus.s_axi_bready = 1'b0;
  endtask

  task automatic waitR(input int dly, output logic [DW-1:0] data, output logic [1:0] resp);
    int n = 0;
    logic stable = 1'b1;
    logic [DW+1:0] first;
    do begin @(negedge clk); n++; end while (!bus.s_axi_rvalid && n < TIMEOUT);
    checkOutput("rValid", bus.s_axi_rvalid, 1'b1);
    first = {bus.s_axi_rdata, bus.s_axi_rresp};
    repeat (dly) begin
      @(negedge clk);
      if (!bus.s_axi_rvalid || {bus.s_axi_rdata, bus.s_axi_rresp} !== first) stable = 1'b0;
    end
    if (dly > 0) checkOutput("rHold", stable, 1'b1);
    data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
    bus.s_axi_rready = 1'b1;
    @(posedge clk); #1; bus.s_axi_rready = 1'b0;
  endtask

  task automatic axiWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                          input int awDly, input int wDly, input int bDly, output logic [1:0] resp);
    fork
      sendAw(addr, awDly);
      sendW(data, strb, wDly);
    join
    waitB(bDly, resp);
  endtask

  task automatic axiRead(input logic [AW-1:0] addr, input int arDly, input int rDly,
                         output logic [DW-1:0] data, output logic [1:0] resp);
    sendAr(addr, arDly);
    waitR(rDly, data, resp);
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    idleBus();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    modelClear();
  endtask

  task automatic applyStimulus(input int count);
    logic [AW-1:0] addr;
    logic [DW-1:0] data, rd;
    logic [3:0]    strb;
    logic [1:0]    resp;
    int            idx;
    for (int t = 0; t < count; t++) begin
      addr = AW'($urandom_range(0, 63));
      idx  = int'(addr[5:2]);
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axiWrite(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
        modelWrite(addr, data, strb);
        checkOutput("rndBResp", resp, (idx < NR) ? 2'b00 : 2'b10);
        checkOutput("rndRegs", regs, modelFlat());
      end else begin
        axiRead(addr, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp);
        checkOutput("rndRData", rd, (idx < NR) ? model[idx] : 32'h0);
        checkOutput("rndRResp", resp, (idx < NR) ? 2'b00 : 2'b10);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]       resp;
    logic [DW-1:0]    rd;
    logic [NR*DW-1:0] snap;
    int               p0, p1, extra;
    int               base [NR];

    idleBus();
    modelClear();
    for (int k = 0; k < NR; k++) expPulse[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReadies", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b000);
    checkOutput("rstValids", {bus.s_axi_rvalid, bus.s_axi_bvalid}, 2'b00);
    checkOutput("rstRData", {bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_bresp}, 0);
    checkOutput("rstRegs", regs, 0);
    checkOutput("rstPulse", pulse, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("postRstReadies", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b111);
    @(posedge clk); #1;

    $display("[TB] full-word write to 0x04");
    p0 = pulseTotal; p1 = pulseCount[1];
    axiWrite(6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
    modelWrite(6'h04, 32'hDEADBEEF, 4'hF);
    checkOutput("t1BResp", resp, 2'b00);
    checkOutput("t1Reg1", regs[63:32], 32'hDEADBEEF);
    checkOutput("t1Regs", regs, modelFlat());
    repeat (2) @(posedge clk); #1;
    checkOutput("t1PulseReg1", pulseCount[1] - p1, 1);
    checkOutput("t1PulseTotal", pulseTotal - p0, 1);

    $display("[TB] partial strobe write");
    axiWrite(6'h04, 32'h11223344, 4'b0101, 0, 0, 0, resp);
    modelWrite(6'h04, 32'h11223344, 4'b0101);
    checkOutput("t3BResp", resp, 2'b00);
    checkOutput("t3Reg1", regs[63:32], 32'hDE22BE44);
    axiRead(6'h04, 0, 0, rd, resp);
    checkOutput("t3RData", rd, 32'hDE22BE44);
    checkOutput("t3RResp", resp, 2'b00);

    $display("[TB] W ahead of AW");
    sendW(32'hCAFEF00D, 4'hF, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t2NoEarlyB", bus.s_axi_bvalid, 1'b0);
    checkOutput("t2Reg2Old", regs[95:64], 32'h0);
    @(posedge clk); #1;
    sendAw(6'h08, 0);
    waitB(0, resp);
    modelWrite(6'h08, 32'hCAFEF00D, 4'hF);
    checkOutput("t2BResp", resp, 2'b00);
    checkOutput("t2Reg2", regs[95:64], 32'hCAFEF00D);
    extra = 0;
    repeat (10) begin @(negedge clk); if (bus.s_axi_bvalid) extra++; end
    checkOutput("t2SingleB", extra, 0);
    @(posedge clk); #1;

    $display("[TB] out-of-range access");
    axiRead(6'h3C, 0, 0, rd, resp);
    checkOutput("t4RResp", resp, 2'b10);
    checkOutput("t4RData", rd, 32'h0);
    snap = regs; p0 = pulseTotal;
    axiWrite(6'h3C, 32'h12345678, 4'hF, 0, 0, 0, resp);
    repeat (2) @(posedge clk); #1;
    checkOutput("t4BResp", resp, 2'b10);
    checkOutput("t4RegsSame", regs, snap);
    checkOutput("t4NoPulse", pulseTotal - p0, 0);

    $display("[TB] stalled responses");
    axiRead(6'h04, 0, 10, rd, resp);
    checkOutput("t5HoldRData", rd, 32'hDE22BE44);
    axiWrite(6'h0C, 32'h0BADF00D, 4'hF, 0, 0, 10, resp);
    modelWrite(6'h0C, 32'h0BADF00D, 4'hF);
    checkOutput("t5HoldBResp", resp, 2'b00);
    checkOutput("t5Regs", regs, modelFlat());

    $display("[TB] random traffic");
    for (int k = 0; k < NR; k++) begin
      base[k] = pulseCount[k];
      expPulse[k] = 0;
    end
    applyStimulus(1000);
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < NR; k++) checkOutput("rndPulseCount", pulseCount[k] - base[k], expPulse[k]);

    $display("[TB] reset between AW and W");
    sendAw(6'h10, 0);
    applyReset(2);
    extra = 0;
    repeat (10) begin @(negedge clk); if (bus.s_axi_bvalid) extra++; end
    checkOutput("t6NoB", extra, 0);
    checkOutput("t6RegsZero", regs, 0);
    @(posedge clk); #1;
    axiWrite(6'h10, 32'h5A5A5A5A, 4'hF, 0, 0, 0, resp);
    modelWrite(6'h10, 32'h5A5A5A5A, 4'hF);
    checkOutput("t6BResp", resp, 2'b00);
    checkOutput("t6Regs", regs, modelFlat());

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
